// File: rtl/flag_loader_pkg.sv
// Shared constants for the flag loader, its consumer (the encoder) and the bench.
// State encoding is fixed so other blocks can decode it.
package flag_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  localparam int FLAG_BYTES_DEF = 24;
  localparam int FLAG_W         = FLAG_BYTES_DEF * 8;
  localparam int TIMEOUT_DEF    = 255;
  localparam int CNT_W_DEF      = 5;

endpackage

// File: rtl/flag_loader_if.sv
// Byte-in / word-out handshake bundle of the flag loader.
// master = byte source plus flag consumer, slave = the loader itself.
interface flag_loader_if
  import flag_loader_pkg::*;
#(
  parameter int FLAG_BYTES = FLAG_BYTES_DEF,
  parameter int CNT_W      = CNT_W_DEF
);

  logic [7:0]              in_byte;
  logic                    in_valid;
  logic                    in_ready;
  logic [FLAG_BYTES*8-1:0] flag;
  logic                    flag_valid;
  logic                    flag_ack;
  logic [CNT_W-1:0]        byte_count;
  logic                    timeout_err;

  modport master (
    output in_byte, in_valid, flag_ack,
    input  in_ready, flag, flag_valid, byte_count, timeout_err
  );

  modport slave (
    input  in_byte, in_valid, flag_ack,
    output in_ready, flag, flag_valid, byte_count, timeout_err
  );

endinterface

// File: rtl/flag_idle_timer.sv
// Inactivity timer: counts enabled, uncleared cycles and flags the cycle on
// which the TIMEOUT_CYCLES-th consecutive idle cycle occurs.
module flag_idle_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] MAX  = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] count;

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != MAX) begin
      count <= count + TW'(1);
    end
  end

  // Combinational so a transfer in the same cycle (clear) suppresses expiry.
  assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/flag_loader.sv
// Byte-serial flag assembler: shifts bytes into a FLAG_BYTES-wide word, then
// holds the word on flag until acked; stalled partial words are discarded.
module flag_loader
  import flag_loader_pkg::*;
#(
  parameter int FLAG_BYTES     = FLAG_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input logic          clk,
  input logic          reset,
  flag_loader_if.slave bus
);

  localparam int               W         = FLAG_BYTES * 8;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FLAG_BYTES - 1);

  state_t         state;
  logic [W-1:0]   shift_reg;
  logic [W-1:0]   shifted;
  logic           xfer;
  logic           expired;

  assign xfer    = bus.in_valid && bus.in_ready;
  assign shifted = (shift_reg << 8) | W'(bus.in_byte);

  flag_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (xfer || state != ST_FILL),
    .enable (state == ST_FILL),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      shift_reg       <= '0;
      bus.in_ready    <= 1'b0;
      bus.flag        <= '0;
      bus.flag_valid  <= 1'b0;
      bus.byte_count  <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.timeout_err <= 1'b0;
      case (state)
        // byte_count is 0 in IDLE, so one completion test covers FLAG_BYTES==1.
        ST_IDLE, ST_FILL: begin
          bus.in_ready <= 1'b1;
          if (xfer) begin
            shift_reg      <= shifted;
            bus.byte_count <= bus.byte_count + CNT_W'(1);
            if (bus.byte_count == LAST_BYTE) begin
              bus.flag       <= shifted;
              bus.flag_valid <= 1'b1;
              bus.in_ready   <= 1'b0;
              state          <= ST_FULL;
            end else begin
              state <= ST_FILL;
            end
          end else if (expired) begin
            shift_reg       <= '0;
            bus.byte_count  <= '0;
            bus.timeout_err <= 1'b1;
            state           <= ST_IDLE;
          end
        end
        ST_FULL: begin
          // flag itself is left alone so the encoder keeps a stable input.
          if (bus.flag_ack) begin
            shift_reg      <= '0;
            bus.flag_valid <= 1'b0;
            bus.byte_count <= '0;
            bus.in_ready   <= 1'b1;
            state          <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/flag_loader.md
Name: flag_loader

Overview:
Byte-serial front end for the license-check datapath. It accepts the candidate flag one byte at a time over a valid/ready handshake and assembles it into a FLAG_BYTES-wide word. It then presents the word, held stable, to the encoder's flag input with a flag_valid/flag_ack handshake. An inactivity timeout discards partially entered flags.

Parameters:
FLAG_BYTES, 24, number of bytes in one flag word (output width FLAG_BYTES*8)
TIMEOUT_CYCLES, 255, idle cycles allowed between bytes in FILL before abort (must be >=1)
CNT_W, 5, width of byte counter; must satisfy 2**CNT_W > FLAG_BYTES

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_byte  input  8  next flag character
in_valid  input  1  in_byte is valid this cycle
in_ready  output  1  loader accepts a byte this cycle (transfer = in_valid & in_ready)
flag  output  FLAG_BYTES*8  assembled flag; first received byte in bits [FLAG_BYTES*8-1 -: 8]
flag_valid  output  1  flag holds a complete word
flag_ack  input  1  consumer has taken flag
byte_count  output  CNT_W  bytes accepted in current word
timeout_err  output  1  one-cycle pulse when a partial word is discarded

Behaviour:
- Reset: sampled on clk only. Forces state IDLE, in_ready=0, flag=0, flag_valid=0, byte_count=0, timeout_err=0, shift register=0 and idle counter=0. Reset wins over every other event, including mid-FILL and while FULL.
- States: IDLE, FILL, FULL. in_ready is registered: 1 in IDLE/FILL, 0 in FULL and during the reset cycle.
- IDLE: on a transfer, shift_reg <= {shift_reg[..-8], in_byte}, byte_count <= 1, go to FILL. If FLAG_BYTES==1, go directly to FULL.
- FILL: each transfer shifts in the byte at the LSB end, increments byte_count and clears the idle counter.
  - No transfer: idle counter increments.
  - Transfer completing byte FLAG_BYTES: flag <= shifted value, flag_valid <= 1, in_ready <= 0, go to FULL. flag is visible the cycle after the last transfer (latency 1).
  - Idle counter reaching TIMEOUT_CYCLES with no transfer: shift_reg <= 0, byte_count <= 0, timeout_err <= 1 for exactly one cycle, go to IDLE.
  - A transfer in the same cycle the counter would expire takes priority; no timeout occurs.
- FULL: flag and flag_valid are held stable and no bytes are accepted. On flag_ack: flag_valid <= 0, byte_count <= 0, shift_reg <= 0, go to IDLE.
  - flag keeps its last value after ack; it is only overwritten by the next completed word.
  - in_valid asserted together with flag_ack is not accepted (in_ready=0 that cycle). in_ready returns to 1 the next cycle.
- flag_ack outside FULL is ignored. No timeout applies in FULL or IDLE.
- The flag output never shows partial words; encoder input changes only on completion.
- Counters saturate and never wrap: byte_count max FLAG_BYTES, idle counter max TIMEOUT_CYCLES.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_FILL=2'd1, ST_FULL=2'd2), the default FLAG_BYTES=24 and the flag width FLAG_W=FLAG_BYTES*8, shared with the encoder and the bench.
- One natural sub-module: flag_idle_timer (clear, enable, expired pulse; parameter TIMEOUT_CYCLES). Everything else stays in flag_loader.

Test Plan:
- Back-to-back load: after reset, stream "shc2024{this_is_wrooong}" with in_valid held high. Required: flag_valid=1 on the cycle after the 24th transfer, flag equals the 192-bit literal, byte_count=24, in_ready=0.
- Gapped load with ack: same 24 bytes with 3-cycle gaps, then flag_ack for 1 cycle. Required: no timeout_err; flag_valid drops the next cycle; flag is retained; byte_count=0; in_ready=1.
- Timeout: send 5 bytes, then idle for TIMEOUT_CYCLES (set to 8). Required: a single-cycle timeout_err, byte_count=0, state IDLE. A new 24-byte load then yields flag equal to only the new bytes.
- Boundary at timeout: send a byte on exactly the cycle the idle counter expires. Required: byte accepted, byte_count increments, no timeout_err.
- Ack collision: in FULL, assert flag_ack and in_valid with in_byte=8'h41 in the same cycle. Required: byte not counted; next cycle in_ready=1 and byte_count=0; 8'h41 accepted only if still presented.
- Reset mid-operation: pulse reset for 1 cycle after 10 bytes, and again while FULL. Required: all outputs zero next cycle, flag=0, then a normal 24-byte load completes correctly.
